// File: rtl/risc_spm_pkg.sv
// rtl/risc_spm_pkg.sv - shared RISC-SPM opcodes, bus select codes and widths
package risc_spm_pkg;

    localparam int WORD_SIZE = 8;
    localparam int OP_SIZE   = 4;
    localparam int SEL1_SIZE = 3;
    localparam int SEL2_SIZE = 2;

    typedef enum logic [OP_SIZE-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_NOT = 4'd4,
        OP_EQZ = 4'd9
    } opcode_e;

    typedef enum logic [SEL1_SIZE-1:0] {
        SEL1_R0 = 3'd0,
        SEL1_R1 = 3'd1,
        SEL1_R2 = 3'd2,
        SEL1_R3 = 3'd3,
        SEL1_PC = 3'd4
    } sel1_e;

    typedef enum logic [SEL2_SIZE-1:0] {
        SEL2_ALU   = 2'd0,
        SEL2_BUS_1 = 2'd1,
        SEL2_MEM   = 2'd2
    } sel2_e;

endpackage

// File: rtl/risc_spm_processing_unit_if.sv
// rtl/risc_spm_processing_unit_if.sv - control-unit/memory to datapath bundle; carry port under RISC_SPM_CARRY_EN
interface risc_spm_processing_unit_if
    import risc_spm_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int Sel1_size = SEL1_SIZE,
    parameter int Sel2_size = SEL2_SIZE
);
    logic                 Load_R0, Load_R1, Load_R2, Load_R3;
    logic                 Load_PC, Inc_PC, Load_IR, Load_Add_R;
    logic                 Load_Reg_Y, Load_Reg_Z;
    logic [Sel1_size-1:0] Sel_Bus_1_Mux;
    logic [Sel2_size-1:0] Sel_Bus_2_Mux;
    logic [word_size-1:0] mem_word;
    logic [word_size-1:0] instruction;
    logic [word_size-1:0] address;
    logic [word_size-1:0] Bus_1;
    logic                 zero;
`ifdef RISC_SPM_CARRY_EN
    logic                 carry;

    modport master (
        output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
               Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
        input  instruction, address, Bus_1, zero, carry
    );
    modport slave (
        input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
               Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
        output instruction, address, Bus_1, zero, carry
    );
`else
    modport master (
        output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
               Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
        input  instruction, address, Bus_1, zero
    );
    modport slave (
        input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR,
               Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, mem_word,
        output instruction, address, Bus_1, zero
    );
`endif
endinterface

// File: rtl/risc_spm_alu.sv
// rtl/risc_spm_alu.sv - combinational RISC-SPM ALU; carry output under RISC_SPM_CARRY_EN
module risc_spm_alu
    import risc_spm_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int op_size   = OP_SIZE
) (
    input  logic [op_size-1:0]   opcode,
    input  logic [word_size-1:0] data_1,
    input  logic [word_size-1:0] data_2,
`ifdef RISC_SPM_CARRY_EN
    output logic                 carry,
`endif
    output logic [word_size-1:0] alu_out
);
    // One extra bit holds carry-out / borrow when the carry register exists.
`ifdef RISC_SPM_CARRY_EN
    localparam int EW = word_size + 1;
`else
    localparam int EW = word_size;
`endif

    logic [EW-1:0] sum;
    logic [EW-1:0] diff;

    assign sum  = EW'(data_1) + EW'(data_2);
    assign diff = EW'(data_2) - EW'(data_1);

    always_comb begin
        alu_out = '0;
        case (opcode)
            OP_ADD:  alu_out = sum[word_size-1:0];
            OP_SUB:  alu_out = diff[word_size-1:0];
            OP_AND:  alu_out = data_1 & data_2;
            OP_NOT:  alu_out = ~data_2;
            OP_EQZ:  alu_out = data_1 ^ data_2;
            default: alu_out = '0;
        endcase
    end

`ifdef RISC_SPM_CARRY_EN
    always_comb begin
        carry = 1'b0;
        case (opcode)
            OP_ADD:  carry = sum[EW-1];
            OP_SUB:  carry = diff[EW-1];
            default: carry = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/risc_spm_processing_unit.sv
// rtl/risc_spm_processing_unit.sv - RISC-SPM datapath: registers, bus muxes, ALU; RISC_SPM_CARRY_EN adds carry flag
module risc_spm_processing_unit
    import risc_spm_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int op_size   = OP_SIZE,
    parameter int Sel1_size = SEL1_SIZE,
    parameter int Sel2_size = SEL2_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    risc_spm_processing_unit_if.slave dp
);
    logic [word_size-1:0] r [4];
    logic [word_size-1:0] pc;
    logic [word_size-1:0] ir;
    logic [word_size-1:0] add_r;
    logic [word_size-1:0] reg_y;
    logic                 reg_z;
    logic [word_size-1:0] bus_1;
    logic [word_size-1:0] bus_2;
    logic [word_size-1:0] alu_out;
    logic [Sel1_size-1:0] sel_1;
    logic [Sel2_size-1:0] sel_2;

    assign sel_1 = dp.Sel_Bus_1_Mux;
    assign sel_2 = dp.Sel_Bus_2_Mux;

    // Unused or unknown selects fall to default so an idle control unit cannot leak x.
    always_comb begin
        bus_1 = '0;
        case (sel_1)
            SEL1_R0: bus_1 = r[0];
            SEL1_R1: bus_1 = r[1];
            SEL1_R2: bus_1 = r[2];
            SEL1_R3: bus_1 = r[3];
            SEL1_PC: bus_1 = pc;
            default: bus_1 = '0;
        endcase
    end

    always_comb begin
        bus_2 = '0;
        case (sel_2)
            SEL2_ALU:   bus_2 = alu_out;
            SEL2_BUS_1: bus_2 = bus_1;
            SEL2_MEM:   bus_2 = dp.mem_word;
            default:    bus_2 = '0;
        endcase
    end

`ifdef RISC_SPM_CARRY_EN
    logic alu_carry;
    logic reg_c;

    risc_spm_alu #(.word_size(word_size), .op_size(op_size)) u_alu (
        .opcode  (ir[word_size-1 -: op_size]),
        .data_1  (reg_y),
        .data_2  (bus_1),
        .carry   (alu_carry),
        .alu_out (alu_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            reg_c <= 1'b0;
        else if (dp.Load_Reg_Z)
            reg_c <= alu_carry;
    end

    assign dp.carry = reg_c;
`else
    risc_spm_alu #(.word_size(word_size), .op_size(op_size)) u_alu (
        .opcode  (ir[word_size-1 -: op_size]),
        .data_1  (reg_y),
        .data_2  (bus_1),
        .alu_out (alu_out)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r[0]  <= '0;
            r[1]  <= '0;
            r[2]  <= '0;
            r[3]  <= '0;
            pc    <= '0;
            ir    <= '0;
            add_r <= '0;
            reg_y <= '0;
            reg_z <= 1'b0;
        end else begin
            if (dp.Load_R0)    r[0]  <= bus_2;
            if (dp.Load_R1)    r[1]  <= bus_2;
            if (dp.Load_R2)    r[2]  <= bus_2;
            if (dp.Load_R3)    r[3]  <= bus_2;
            if (dp.Load_IR)    ir    <= bus_2;
            if (dp.Load_Add_R) add_r <= bus_2;
            if (dp.Load_Reg_Y) reg_y <= bus_2;
            if (dp.Load_Reg_Z) reg_z <= (alu_out == '0);
            // An explicit jump target wins over sequential fetch.
            if (dp.Load_PC)
                pc <= bus_2;
            else if (dp.Inc_PC)
                pc <= pc + 1'b1;
        end
    end

    assign dp.instruction = ir;
    assign dp.address     = add_r;
    assign dp.Bus_1       = bus_1;
    assign dp.zero        = reg_z;

endmodule
